// File: rtl/uart_pkg.sv
// Shared types and constants for the UART output path: serializer state,
// FIFO entry layout and the loader handshake bytes.
package uart_pkg;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  localparam logic [7:0] LOADER_ACK_START = 8'h99;
  localparam logic [7:0] LOADER_ACK_DONE  = 8'haa;
  localparam logic [2:0] BYTES_PER_WORD   = 3'd4;

  typedef struct packed {
    logic        is_byte;
    logic [31:0] data;
  } tx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; a pushed entry becomes
// visible to the reader one cycle after the push (no bypass path).
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_rdata = r_rdata;

  // Storage array, left unreset so it can map onto RAM
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rdata  <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_sender.sv
// Buffers CPU words/bytes and serializes them onto the shared UART sender,
// one tx_start pulse per byte with a holdoff cycle between pulses.
module uart_word_sender
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [31:0]                 i_wr_data,
  input  logic                        i_wr_is_byte,
  input  logic                        i_tx_busy,
  output logic                        o_tx_start,
  output logic [7:0]                  o_sdata,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_idle
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_entry_t   w_wr_entry;
  tx_entry_t   w_rd_entry;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic [CW-1:0] w_count;

  tx_state_t   r_state;
  logic [31:0] r_shift;
  logic [2:0]  r_left;
  logic        r_is_byte;
  logic        r_loaded;
  logic        r_holdoff;
  logic        r_tx_start;
  logic [7:0]  r_sdata;

  logic [31:0] w_shift;
  logic [31:0] w_shift_next;
  logic [2:0]  w_left;
  logic        w_is_byte;
  logic [7:0]  w_byte;
  logic        w_fire;

  assign w_wr_entry = '{is_byte: i_wr_is_byte, data: i_wr_data};
  assign w_pop      = (r_state == TX_IDLE) & ~w_empty;

  sync_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_wr_valid),
    .i_pop   (w_pop),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The popped entry lands in the FIFO read register one cycle after the pop,
  // so the first SEND cycle works straight from it before the shift reg owns it.
  assign w_shift      = r_loaded ? r_shift   : w_rd_entry.data;
  assign w_is_byte    = r_loaded ? r_is_byte : w_rd_entry.is_byte;
  assign w_left       = r_loaded ? r_left    : (w_rd_entry.is_byte ? 3'd1 : BYTES_PER_WORD);
  assign w_byte       = (w_is_byte || !MSB_FIRST) ? w_shift[7:0] : w_shift[31:24];
  assign w_shift_next = MSB_FIRST ? {w_shift[23:0], 8'h00} : {8'h00, w_shift[31:8]};
  assign w_fire       = (r_state == TX_SEND) & i_enable & ~i_tx_busy & ~r_holdoff;

  // Serializer FSM with registered tx_start/sdata and post-pulse holdoff
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= TX_IDLE;
      r_shift    <= 32'h0000_0000;
      r_left     <= 3'd0;
      r_is_byte  <= 1'b0;
      r_loaded   <= 1'b0;
      r_holdoff  <= 1'b0;
      r_tx_start <= 1'b0;
      r_sdata    <= 8'h00;
    end else begin
      r_tx_start <= w_fire;
      r_holdoff  <= w_fire;
      if (w_fire) begin
        r_sdata <= w_byte;
      end
      case (r_state)
        TX_IDLE: begin
          r_loaded <= 1'b0;
          if (!w_empty) begin
            r_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          r_loaded  <= 1'b1;
          r_is_byte <= w_is_byte;
          if (w_fire) begin
            r_shift <= w_shift_next;
            r_left  <= w_left - 3'd1;
            if (w_left == 3'd1) begin
              r_state <= TX_IDLE;
            end
          end else begin
            r_shift <= w_shift;
            r_left  <= w_left;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_wr_ready   = ~w_full;
  assign o_fifo_count = w_count;
  assign o_tx_start   = r_tx_start;
  assign o_sdata      = r_sdata;
  assign o_idle       = (w_count == '0) & (r_state == TX_IDLE);

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench for uart_word_sender: an MSB-first and an LSB-first instance
// share stimulus; a negedge monitor collects bytes and models tx_busy.
module tb_uart_word_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_is_byte;
  logic        tx_busy;

  logic        wr_ready,  wr_ready2;
  logic        tx_start,  tx_start2;
  logic [7:0]  sdata,     sdata2;
  logic [4:0]  fifo_count, fifo_count2;
  logic        idle,      idle2;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  q[$];
  logic [7:0]  q2[$];
  bit          busy_en = 1'b0;
  int          busy_cnt = 0;
  logic        prev_start = 1'b0;
  logic        prev_start2 = 1'b0;

  always #5 clk = ~clk;

  uart_word_sender #(.FIFO_DEPTH(16), .MSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_is_byte(wr_is_byte),
    .i_tx_busy(tx_busy), .o_tx_start(tx_start), .o_sdata(sdata),
    .o_fifo_count(fifo_count), .o_idle(idle)
  );

  uart_word_sender #(.FIFO_DEPTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready2), .i_wr_data(wr_data), .i_wr_is_byte(wr_is_byte),
    .i_tx_busy(tx_busy), .o_tx_start(tx_start2), .o_sdata(sdata2),
    .o_fifo_count(fifo_count2), .o_idle(idle2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte capture, adjacency check and tx_busy model (busy rises one cycle after tx_start, 10 cycles)
  always @(negedge clk) begin
    if (busy_en) begin
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) busy_cnt = 10;
    end else begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end
    if (tx_start) begin
      check("no_back_to_back", {31'd0, prev_start}, 32'd0);
      q.push_back(sdata);
    end
    if (tx_start2) begin
      check("no_back_to_back_lsb", {31'd0, prev_start2}, 32'd0);
      q2.push_back(sdata2);
    end
    prev_start  = tx_start;
    prev_start2 = tx_start2;
  end

  task automatic push(input logic [31:0] d, input logic is_byte);
    @(negedge clk);
    wr_valid   = 1'b1;
    wr_data    = d;
    wr_is_byte = is_byte;
    @(negedge clk);
    wr_valid   = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int c = 0;
    while (q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(idle && idle2) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_data = 32'h0; wr_is_byte = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_sdata", {24'd0, sdata}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full word, MSB first, with busy model
    busy_en = 1'b1;
    q.delete(); q2.delete();
    push(32'h11223344, 1'b0);
    wait_bytes(4, 200, "t1_bytes");
    check("t1_b0", {24'd0, q[0]}, 32'h11);
    check("t1_b1", {24'd0, q[1]}, 32'h22);
    check("t1_b2", {24'd0, q[2]}, 32'h33);
    check("t1_b3", {24'd0, q[3]}, 32'h44);
    wait_idle(100);
    check("t1_count", {27'd0, fifo_count}, 32'd0);
    check("t1_n", q.size(), 32'd4);

    // 2: single byte
    repeat (15) @(negedge clk);
    q.delete(); q2.delete();
    push(32'hDEADBE7A, 1'b1);
    repeat (40) @(negedge clk);
    check("t2_n", q.size(), 32'd1);
    if (q.size() > 0) check("t2_b", {24'd0, q[0]}, 32'h7A);
    check("t2_lsb_n", q2.size(), 32'd1);

    // 3: fill while disabled, overflow dropped, drain in order
    busy_en = 1'b0;
    enable  = 1'b0;
    repeat (5) @(negedge clk);
    q.delete(); q2.delete();
    for (int i = 0; i < 18; i++) begin
      push({8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)}, 1'b0);
    end
    check("t3_ready", {31'd0, wr_ready}, 32'd0);
    check("t3_count", {27'd0, fifo_count}, 32'd16);
    check("t3_idle", {31'd0, idle}, 32'd0);
    check("t3_no_tx", q.size(), 32'd0);
    enable = 1'b1;
    wait_bytes(68, 1500, "t3_bytes");
    repeat (30) @(negedge clk);
    check("t3_n", q.size(), 32'd68);
    for (int i = 0; i < 17; i++) begin
      if (q.size() >= 4 * i + 4) begin
        w = {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
        check("t3_word", w, {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)});
      end
    end
    wait_idle(100);

    // 4: enable dropped mid-word
    busy_en = 1'b1;
    q.delete(); q2.delete();
    push(32'hAABBCCDD, 1'b0);
    wait_bytes(2, 200, "t4_first_two");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_stall", q.size(), 32'd2);
    enable = 1'b1;
    wait_bytes(4, 200, "t4_rest");
    if (q.size() >= 4) begin
      check("t4_b0", {24'd0, q[0]}, 32'hAA);
      check("t4_b1", {24'd0, q[1]}, 32'hBB);
      check("t4_b2", {24'd0, q[2]}, 32'hCC);
      check("t4_b3", {24'd0, q[3]}, 32'hDD);
    end
    wait_idle(100);

    // 5: latency t+2 and LSB-first order
    repeat (15) @(negedge clk);
    busy_en = 1'b0;
    repeat (2) @(negedge clk);
    q.delete(); q2.delete();
    push(32'h11223344, 1'b0);
    check("t5_lat_t0", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("t5_lat_t1", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("t5_lat_t2", {31'd0, tx_start}, 32'd1);
    check("t5_first", {24'd0, sdata}, 32'h11);
    check("t5_first_lsb", {24'd0, sdata2}, 32'h44);
    repeat (20) @(negedge clk);
    check("t5_lsb_n", q2.size(), 32'd4);
    if (q2.size() >= 4) begin
      w = {q2[0], q2[1], q2[2], q2[3]};
      check("t5_lsb_order", w, 32'h44332211);
    end

    // 6: reset mid-word with three words queued
    busy_en = 1'b1;
    q.delete(); q2.delete();
    for (int i = 0; i < 4; i++) push(32'h55667788 + 32'(i), 1'b0);
    begin
      int c = 0;
      while (!tx_start && c < 100) begin
        @(negedge clk);
        c++;
      end
    end
    check("t6_pre_start", {31'd0, tx_start}, 32'd1);
    check("t6_pre_count", {27'd0, fifo_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", {31'd0, tx_start}, 32'd0);
    check("t6_rst_count", {27'd0, fifo_count}, 32'd0);
    check("t6_rst_idle", {31'd0, idle}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete(); q2.delete();
    repeat (60) @(negedge clk);
    check("t6_no_stale", q.size(), 32'd0);
    check("t6_idle", {31'd0, idle}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
